// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared types and constants for the UART transmit path.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PAR,
    STOP
  } uart_tx_state_t;

  localparam int PAR_NONE = 0;
  localparam int PAR_EVEN = 1;
  localparam int PAR_ODD  = 2;

  localparam int DEFAULT_CLKS_PER_BIT = 868;

  function automatic logic parity_bit(input logic [7:0] data, input int mode);
    return (mode == PAR_ODD) ? ~(^data) : (^data);
  endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// rtl/uart_bit_timer.sv - bit-period timer; bit_done marks the last cycle of each bit.
module uart_bit_timer
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic clk,
  input  logic rst,
  input  logic restart,
  output logic bit_done
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign bit_done = (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q + CNT_W'(1);
    if (restart || bit_done) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_tx.sv
// rtl/uart_tx.sv - UART transmitter: one-deep holding register, 8 data bits LSB-first,
// optional parity, one stop bit, back-to-back frames without idle gap.
module uart_tx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int PARITY       = PAR_NONE
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  output logic       tx,
  output logic       busy
);

  uart_tx_state_t state_q, state_d;
  logic [7:0]     hold_q, hold_d;
  logic           hold_full_q, hold_full_d;
  logic [7:0]     shift_q, shift_d;
  logic [2:0]     idx_q, idx_d;
  logic           par_q, par_d;
  logic           tx_q, tx_d;
  logic           bit_done;
  logic           load;
  logic           accept;

  // Timer is held at zero while idle so START always gets a full bit time.
  uart_bit_timer #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_bit_timer (
    .clk     (clk),
    .rst     (rst),
    .restart (state_q == IDLE),
    .bit_done(bit_done)
  );

  assign in_ready = ~hold_full_q;
  assign accept   = in_valid && ~hold_full_q;
  assign busy     = (state_q != IDLE) || hold_full_q;
  assign tx       = tx_q;

  always_comb begin
    state_d     = state_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    shift_d     = shift_q;
    idx_d       = idx_q;
    par_d       = par_q;
    load        = 1'b0;

    case (state_q)
      IDLE: begin
        if (hold_full_q) begin
          load    = 1'b1;
          state_d = START;
        end
      end
      START: begin
        if (bit_done) begin
          state_d = DATA;
          idx_d   = 3'd0;
        end
      end
      DATA: begin
        if (bit_done) begin
          shift_d = shift_q >> 1;
          idx_d   = idx_q + 3'd1;
          if (idx_q == 3'd7) begin
            state_d = (PARITY != PAR_NONE) ? PAR : STOP;
          end
        end
      end
      PAR: begin
        if (bit_done) begin
          state_d = STOP;
        end
      end
      STOP: begin
        if (bit_done) begin
          if (hold_full_q) begin
            load    = 1'b1;
            state_d = START;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (load) begin
      shift_d     = hold_q;
      par_d       = parity_bit(hold_q, PARITY);
      hold_full_d = 1'b0;
    end
    // A byte accepted on the load edge overrides the clear above.
    if (accept) begin
      hold_d      = in_data;
      hold_full_d = 1'b1;
    end

    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_d[0];
      PAR:     tx_d = par_d;
      default: tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      shift_q     <= '0;
      idx_q       <= '0;
      par_q       <= 1'b0;
      tx_q        <= 1'b1;
    end else begin
      state_q     <= state_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      shift_q     <= shift_d;
      idx_q       <= idx_d;
      par_q       <= par_d;
      tx_q        <= tx_d;
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// tb/tb_uart_tx.sv - scoreboard bench for uart_tx across divisor and parity variants.
`timescale 1ns/1ps
module tb_uart_tx;

  localparam int N = 4;

  typedef struct {
    logic [10:0] bits;
    int          start;
  } exp_t;

  int   tests = 0;
  int   fails = 0;
  int   cyc   = 0;
  logic clk   = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic int cpb_of(input int i);
    return (i == 3) ? 1 : 4;
  endfunction

  function automatic int par_of(input int i);
    return (i == 1) ? 1 : (i == 2) ? 2 : 0;
  endfunction

  // Line levels in transmit order: start, d0..d7, [parity], stop (unused slots high).
  function automatic logic [10:0] frame_bits(input logic [7:0] d, input int par);
    logic [10:0] b;
    int          ones;
    ones = $countones(d);
    b    = '1;
    b[0] = 1'b0;
    for (int k = 0; k < 8; k++) b[k+1] = d[k];
    if (par == 1) b[9] = ((ones % 2) == 1);
    if (par == 2) b[9] = ((ones % 2) == 0);
    return b;
  endfunction

  task automatic chk(input string name, input int d, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s dut%0d cyc=%0d: got %0h expected %0h", name, d, cyc, act, exp);
    end
  endtask

  for (genvar gi = 0; gi < N; gi++) begin : g
    localparam int CPB = cpb_of(gi);
    localparam int PAR = par_of(gi);
    localparam int NB  = (PAR == 0) ? 10 : 11;

    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic       tx;
    logic       busy;
    logic [7:0] in_data;

    uart_tx #(
      .CLKS_PER_BIT(CPB),
      .PARITY      (PAR)
    ) dut (
      .clk     (clk),
      .rst     (rst),
      .in_data (in_data),
      .in_valid(in_valid),
      .in_ready(in_ready),
      .tx      (tx),
      .busy    (busy)
    );

    exp_t q[$];
    exp_t cur;
    bit   active   = 1'b0;
    bit   have_any = 1'b0;
    bit   fin      = 1'b0;
    int   acc_last, start_last, end_last;
    int   mp;

    always @(negedge clk) begin
      if (rst) begin
        active = 1'b0;
      end else if (active) begin
        mp = cyc - cur.start;
        chk("tx_bit", gi, tx, cur.bits[mp / CPB]);
        if (mp == NB * CPB - 1) active = 1'b0;
      end else if (tx !== 1'b1) begin
        if (q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_start dut%0d cyc=%0d: got tx=%0b expected 1", gi, cyc, tx);
        end else begin
          cur = q.pop_front();
          chk("frame_start", gi, cyc, cur.start);
          cur.start = cyc;
          chk("tx_bit", gi, tx, cur.bits[0]);
          active = 1'b1;
        end
      end
    end

    task automatic step(input logic v, input logic [7:0] d, output bit acc);
      bit rdy_exp;
      bit busy_exp;
      int a;
      int s;
      rdy_exp = !(have_any && cyc >= acc_last && cyc < start_last);
      busy_exp = have_any && cyc < end_last;
      chk("in_ready", gi, in_ready, rdy_exp);
      chk("busy", gi, busy, busy_exp);
      in_valid = v;
      in_data  = d;
      acc      = v && rdy_exp;
      if (acc) begin
        a = cyc + 1;
        s = a + 1;
        if (have_any && end_last > s) s = end_last;
        q.push_back('{frame_bits(d, PAR), s});
        acc_last   = a;
        start_last = s;
        end_last   = s + NB * CPB;
        have_any   = 1'b1;
      end
      @(negedge clk);
    endtask

    task automatic send(input logic [7:0] d);
      bit acc;
      int n;
      n = 0;
      do begin
        step(1'b1, d, acc);
        n++;
      end while (!acc && n < 1000);
      if (!acc) chk("send_timeout", gi, 0, 1);
    endtask

    task automatic drain();
      bit acc;
      int n;
      n = 0;
      while (have_any && cyc < end_last + 2 && n < 5000) begin
        step(1'b0, 8'($urandom), acc);
        n++;
      end
      chk("frames_pending", gi, q.size(), 0);
      chk("monitor_idle", gi, active, 0);
    endtask

    initial begin
      bit acc;
      int n;
      rst      = 1'b1;
      in_valid = 1'b0;
      in_data  = 8'h00;
      @(negedge clk);
      @(negedge clk);
      chk("reset_tx", gi, tx, 1);
      chk("reset_in_ready", gi, in_ready, 1);
      chk("reset_busy", gi, busy, 0);
      #2 rst = 1'b0;
      @(negedge clk);

      send(8'h55); drain();
      send(8'h07); drain();
      send(8'h81); drain();

      // Valid held high across both bytes; the second waits for the first to load.
      send(8'hA5);
      send(8'h3C);
      drain();

      for (int k = 0; k < 300; k++) begin
        step(($urandom % 4) != 0, 8'($urandom), acc);
      end
      drain();

      // Reset while the frame is in data bit 3.
      send(8'hFF);
      n = 0;
      while (cyc < start_last + 4 * CPB && n < 1000) begin
        step(1'b0, 8'h00, acc);
        n++;
      end
      #2 rst = 1'b1;
      #1;
      chk("midreset_tx", gi, tx, 1);
      chk("midreset_in_ready", gi, in_ready, 1);
      chk("midreset_busy", gi, busy, 0);
      q.delete();
      have_any = 1'b0;
      in_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      #2 rst = 1'b0;
      @(negedge clk);
      send(8'h00);
      drain();
      fin = 1'b1;
    end
  end

  initial begin
    while (!(g[0].fin && g[1].fin && g[2].fin && g[3].fin) && cyc < 60000) @(posedge clk);
    if (!(g[0].fin && g[1].fin && g[2].fin && g[3].fin)) begin
      tests++;
      fails++;
      $display("FAIL timeout: got cyc=%0d expected all streams finished", cyc);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
